// File: rtl/cdb_rr_arbiter.sv
// Round-robin arbiter that drives one registered common-data-bus slot from N_REQ producers.
// Latency: one cycle from the accepting edge to out_valid/out_data/out_src.
// Backpressure: out_ready=0 with a held beat stalls everything and no req_ready is raised; flush drops the beat.
module cdb_rr_arbiter #(
    parameter int WIDTH     = 32,
    parameter int N_REQ     = 4,
    localparam int SRC_WIDTH = $clog2(N_REQ)
) (
    input  logic                   clk,
    input  logic                   rst_aL,
    input  logic                   flush,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   out_valid,
    output logic [WIDTH-1:0]       out_data,
    output logic [SRC_WIDTH-1:0]   out_src,
    input  logic                   out_ready
);

    logic                 out_valid_q, out_valid_d;
    logic [WIDTH-1:0]     out_data_q,  out_data_d;
    logic [SRC_WIDTH-1:0] out_src_q,   out_src_d;
    logic [SRC_WIDTH-1:0] ptr_q,       ptr_d;

    logic                 load_en;
    logic                 any_req;
    logic                 grant_en;
    logic [SRC_WIDTH-1:0] gnt_idx;

    assign load_en  = !out_valid_q || out_ready;
    assign any_req  = |req_valid;
    // A grant is only issued when the slot can actually take the beat this edge.
    assign grant_en = load_en && any_req && !flush && rst_aL;

    // Rotating priority search: first valid requester at or after ptr, wrapping at N_REQ-1.
    always_comb begin
        int  idx;
        logic found;
        gnt_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = int'(ptr_q) + k;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req_valid[idx]) begin
                found   = 1'b1;
                gnt_idx = SRC_WIDTH'(idx);
            end
        end
    end

    // One-hot accept towards the winning requester; the same decode picks the payload.
    always_comb begin
        req_ready = '0;
        if (grant_en) begin
            req_ready[gnt_idx] = 1'b1;
        end
    end

    // Next-state for the output slot and the priority pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (load_en && any_req) begin
            out_valid_d = 1'b1;
            out_data_d  = req_data[int'(gnt_idx)*WIDTH +: WIDTH];
            out_src_d   = gnt_idx;
            ptr_d       = (gnt_idx == SRC_WIDTH'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
        end else if (load_en) begin
            out_valid_d = 1'b0;
        end
    end

    // Output slot and pointer registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_aL) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_cdb_rr_arbiter.sv
module tb_cdb_rr_arbiter;

    localparam int W = 8;
    localparam int N = 4;
    localparam int SW = $clog2(N);

    logic             clk;
    logic             rst_aL;
    logic             flush;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     req_ready;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [SW-1:0]    out_src;
    logic             out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    cdb_rr_arbiter #(.WIDTH(W), .N_REQ(N)) dut (
        .clk       (clk),
        .rst_aL    (rst_aL),
        .flush     (flush),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int         m_ptr;
    bit         m_ov;
    logic [W-1:0] m_od;
    int         m_os;
    bit         m_live = 0;

    // Winner by rotating priority, -1 if nobody requests.
    function automatic int pick(input int ptr, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] exp_ready();
        int g;
        logic [N-1:0] r;
        r = '0;
        g = pick(m_ptr, req_valid);
        if (rst_aL && !flush && (!m_ov || out_ready) && g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    always @(posedge clk) begin
        int g;
        if (!rst_aL) begin
            m_ov = 0; m_od = '0; m_os = 0; m_ptr = 0; m_live = 1;
        end else if (flush) begin
            m_ov = 0;
        end else if (!m_ov || out_ready) begin
            g = pick(m_ptr, req_valid);
            if (g >= 0) begin
                m_ov = 1; m_od = req_data[g*W +: W]; m_os = g; m_ptr = (g + 1) % N;
            end else begin
                m_ov = 0;
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    always @(negedge clk) begin
        if (m_live) begin
            check("model_req_ready", 32'(req_ready), 32'(exp_ready()));
            check("model_out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                check("model_out_data", 32'(out_data), 32'(m_od));
                check("model_out_src", 32'(out_src), 32'(m_os));
            end
        end
    end

    task automatic cyc; @(posedge clk); #1; endtask
    task automatic mid; @(negedge clk); #1; endtask

    logic [N-1:0] last_rdy;

    initial begin
        rst_aL = 1'b0; flush = 1'b0; out_ready = 1'b1; req_valid = 4'b1111;
        for (int i = 0; i < N; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);

        // 1. reset with all requesting
        cyc(); cyc();
        mid();
        check("rst_req_ready", 32'(req_ready), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        check("rst_out_data", 32'(out_data), 32'h0);
        check("rst_out_src", 32'(out_src), 32'h0);
        cyc();
        rst_aL = 1'b1;
        mid();
        check("first_grant", 32'(req_ready), 32'h1);
        cyc();

        // 2. round robin, all requesting
        for (int i = 0; i < 6; i++) begin
            mid();
            check("rr_out_src", 32'(out_src), 32'(i % 4));
            check("rr_out_data", 32'(out_data), 32'h0A0 + 32'(i % 4));
            check("rr_req_ready", 32'(req_ready), 32'(1 << ((i + 1) % 4)));
            cyc();
        end

        // 3. stall with A2 held, req 3 waiting
        out_ready = 1'b0; req_valid = 4'b1000;
        for (int i = 0; i < 3; i++) begin
            mid();
            check("stall_req_ready", 32'(req_ready), 32'h0);
            check("stall_out_data", 32'(out_data), 32'hA2);
            cyc();
        end
        out_ready = 1'b1;
        mid();
        check("unstall_req_ready", 32'(req_ready), 32'h8);
        cyc();
        mid();
        check("unstall_no_bubble", 32'({out_valid, out_data}), 32'h1A3);

        // move ptr to 3 via a lone req 2
        req_valid = 4'b0100;
        cyc();

        // 4. wrap and skip
        req_valid = 4'b0101;
        mid();
        check("wrap_grant0", 32'(req_ready), 32'h1);
        cyc(); mid();
        check("wrap_src0", 32'(out_src), 32'h0);
        check("skip_grant2", 32'(req_ready), 32'h4);
        cyc(); mid();
        check("skip_src2", 32'(out_src), 32'h2);
        check("wrap_grant0b", 32'(req_ready), 32'h1);
        cyc(); mid();
        check("wrap_src0b", 32'(out_src), 32'h0);

        // 5. flush with src 1 in the slot
        req_valid = 4'b0010;
        cyc();
        flush = 1'b1; req_valid = 4'b1111;
        mid();
        check("flush_pre_src", 32'(out_src), 32'h1);
        check("flush_req_ready", 32'(req_ready), 32'h0);
        cyc();
        flush = 1'b0;
        mid();
        check("flush_out_valid", 32'(out_valid), 32'h0);
        check("flush_ptr_kept", 32'(req_ready), 32'h4);
        cyc(); mid();
        check("flush_resume_src", 32'(out_src), 32'h2);

        // 6. reset mid-stream
        cyc(); cyc();
        rst_aL = 1'b0;
        cyc();
        rst_aL = 1'b1;
        mid();
        check("midrst_out_valid", 32'(out_valid), 32'h0);
        check("midrst_req_ready", 32'(req_ready), 32'h1);
        cyc(); mid();
        check("midrst_src0", 32'(out_src), 32'h0);
        cyc();

        // Randomized traffic; requesters hold valid/data until accepted, may drop.
        last_rdy = '0;
        for (int c = 0; c < 3000; c++) begin
            mid();
            last_rdy = req_ready;
            cyc();
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && !last_rdy[i] && $urandom_range(9) != 0) begin
                    // keep pending request unchanged
                end else begin
                    req_valid[i] = ($urandom_range(2) != 0);
                    req_data[i*W +: W] = 8'($urandom);
                end
            end
            out_ready = ($urandom_range(3) != 0);
            flush     = ($urandom_range(19) == 0);
            rst_aL    = ($urandom_range(99) != 0);
        end
        rst_aL = 1'b1;
        mid();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
